// File: rtl/stage_evaluator.sv
// stage_evaluator: per-stage weak-classifier accumulator for the Haar cascade.
// Each cycle one node result picks a left/right leaf value; leaves are summed
// with saturation over the stage and the final sum is compared against the
// stage threshold to produce stage_status.
// Optional feature macro: STAGE_EVAL_NODE_CHECK_EN adds a per-stage node
// counter (node_count) and a sticky mismatch flag (count_err) against
// expected_nodes.
module stage_evaluator #(
  parameter int FEAT_W = 20,
  parameter int VAL_W  = 12,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rst_local,
  input  logic                     node_valid,
  input  logic signed [FEAT_W-1:0] feature_sum,
  input  logic signed [FEAT_W-1:0] node_threshold,
  input  logic signed [VAL_W-1:0]  left_val,
  input  logic signed [VAL_W-1:0]  right_val,
  input  logic                     last_node,
  input  logic signed [ACC_W-1:0]  stage_threshold,
`ifdef STAGE_EVAL_NODE_CHECK_EN
  input  logic [7:0]               expected_nodes,
  output logic [7:0]               node_count,
  output logic                     count_err,
`endif
  output logic                     stage_status,
  output logic                     status_valid,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1 registers: selected leaf and its valid/last qualifiers.
  logic signed [VAL_W-1:0] leaf_r;
  logic                    v1;
  logic                    l1;

  // Stage 2 qualifiers that trail the accumulator update by one cycle.
  logic v2;
  logic l2;

  // Saturating-add datapath.
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] acc_next;
  logic                    clamp;

  // Stage 1: choose the leaf from the node comparison and register it.
  // NOTE: sequential state is assigned only with <= so every register samples
  // the pre-edge values of its sources, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leaf_r <= '0;
      v1     <= 1'b0;
      l1     <= 1'b0;
    end else if (rst_local) begin
      // NOTE: rst_local is a synchronous clear layered under the async rst;
      // it wins over a node presented in the same cycle, which is dropped.
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= node_valid;
      l1 <= node_valid & last_node;
      if (node_valid) begin
        leaf_r <= (feature_sum < node_threshold) ? left_val : right_val;
      end
    end
  end

  // Saturating add of the sign-extended leaf at one extra bit of headroom.
  // NOTE: every output of this block is given a value before any branch so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-VAL_W){leaf_r[VAL_W-1]}}, leaf_r};
    acc_next = sum_wide[ACC_W-1:0];
    clamp    = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      clamp    = 1'b1;
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Stage 2: accumulate the leaf, track sticky saturation, forward qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
      v2  <= 1'b0;
      l2  <= 1'b0;
    end else if (rst_local) begin
      acc <= '0;
      sat <= 1'b0;
      v2  <= 1'b0;
      l2  <= 1'b0;
    end else begin
      v2 <= v1;
      l2 <= l1;
      if (v1) begin
        acc <= acc_next;
        if (clamp) begin
          sat <= 1'b1;
        end
      end
    end
  end

  // Stage 3: compare the completed stage sum and pulse status_valid.
  // stage_status survives rst_local because the control unit samples it then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_status <= 1'b0;
      status_valid <= 1'b0;
    end else if (rst_local) begin
      status_valid <= 1'b0;
    end else begin
      status_valid <= v2 & l2;
      if (v2 && l2) begin
        stage_status <= (acc >= stage_threshold);
      end
    end
  end

`ifdef STAGE_EVAL_NODE_CHECK_EN
  // Count accepted nodes and flag a mismatch when the stage result is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_count <= '0;
      count_err  <= 1'b0;
    end else if (rst_local) begin
      node_count <= '0;
      count_err  <= 1'b0;
    end else begin
      if (node_valid && node_count != 8'hFF) begin
        node_count <= node_count + 8'd1;
      end
      if (v2 && l2 && node_count != expected_nodes) begin
        count_err <= 1'b1;
      end
    end
  end
`endif

endmodule
